fpadd_result_collector: RTL and testbench

//  Receiving end of the fp16 adder's output stream (valid_out/result/overflow/zero/NaN/precisionLost).
//  The adder has no backpressure, so this block does three jobs:
//  - buffers results in a FIFO and presents them downstream over ready/valid;
//  - issues credits upstream so the operand issuer never overruns the FIFO;
//  - keeps sticky exception flags plus protocol-error status.

---
 rtl/fpadd_result_collector_if.sv | 48 ++++
 rtl/fpadd_result_collector.sv | 122 ++++++++++++
 tb/tb_fpadd_result_collector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpadd_result_collector_if.sv
// Bundle of the collector's upstream (adder stream and credit) and downstream
// (ready/valid head) signals. The slave modport is the collector's view; the
// master modport is the view of whatever drives and consumes it.
interface fpadd_result_collector_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  // Upstream credit handshake
  logic          issue_fire;
  logic          issue_ok;

  // Adder output stream
  logic          in_valid;
  logic [15:0]   in_result;
  logic          in_overflow;
  logic          in_zero;
  logic          in_nan;
  logic          in_precision_lost;

  // Downstream FIFO head
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [3:0]    out_flags;

  // Status
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [3:0]    sticky_flags;
  logic          sticky_clr;
  logic          drop_err;
  logic          proto_err;

  modport slave (
    input  issue_fire, in_valid, in_result, in_overflow, in_zero, in_nan,
           in_precision_lost, out_ready, sticky_clr,
    output issue_ok, out_valid, out_data, out_flags, count, inflight,
           sticky_flags, drop_err, proto_err
  );

  modport master (
    output issue_fire, in_valid, in_result, in_overflow, in_zero, in_nan,
           in_precision_lost, out_ready, sticky_clr,
    input  issue_ok, out_valid, out_data, out_flags, count, inflight,
           sticky_flags, drop_err, proto_err
  );
endinterface

// File: rtl/fpadd_result_collector.sv
// Receiving end of the fp16 adder stream. Buffers results in a
// first-word-fall-through FIFO, hands out issue credits so the adder can never
// overrun the FIFO, and keeps sticky exception and protocol-error status.
module fpadd_result_collector #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  fpadd_result_collector_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  // Elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (LATENCY < 1 || LATENCY > DEPTH) begin : g_bad_latency
    $error("LATENCY must be between 1 and DEPTH");
  end

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] inflight_q;
  logic [3:0]    sticky_q;
  logic          drop_err_q;
  logic          proto_err_q;

  logic [3:0]    flags_in;
  logic [19:0]   head;
  logic [CW:0]   credit_sum;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          proto_evt;
  logic          credit_ok;

  assign flags_in   = {bus.in_nan, bus.in_overflow, bus.in_zero, bus.in_precision_lost};
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = (count_q != '0) && bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = bus.in_valid && (!full || pop);
  assign drop       = bus.in_valid && full && !pop;
  // Credit looks only at registered state; a same-cycle pop is credited next cycle.
  assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
  assign credit_ok  = (credit_sum < (CW + 1)'(DEPTH));
  assign proto_evt  = (bus.issue_fire && !credit_ok) ||
                      (bus.in_valid && (inflight_q == '0) && !bus.issue_fire);

  // Result storage: written on accepted pushes only
  // NOTE: the data array has no reset; emptiness is tracked by count_q and the
  // head is masked while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {flags_in, bus.in_result};
  end

  // FIFO pointers and occupancy
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // In-flight accounting, saturating at 0 and DEPTH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= '0;
    end else if (bus.issue_fire && !bus.in_valid) begin
      if (inflight_q != CW'(DEPTH)) inflight_q <= inflight_q + 1'b1;
    end else if (bus.in_valid && !bus.issue_fire) begin
      if (inflight_q != '0) inflight_q <= inflight_q - 1'b1;
    end
  end

  // Sticky status; a coinciding set event wins over clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_q    <= '0;
      drop_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      sticky_q    <= (bus.sticky_clr ? 4'b0000 : sticky_q) |
                     (bus.in_valid ? flags_in : 4'b0000);
      drop_err_q  <= (drop_err_q  && !bus.sticky_clr) || drop;
      proto_err_q <= (proto_err_q && !bus.sticky_clr) || proto_evt;
    end
  end

  // Head presentation, forced to zero while empty
  // NOTE: every output gets a default first so no path through the block
  // leaves a value held, which would infer a latch.
  always_comb begin
    head          = mem[rd_ptr];
    bus.out_valid = (count_q != '0);
    bus.out_data  = '0;
    bus.out_flags = '0;
    if (bus.out_valid) begin
      bus.out_data  = head[15:0];
      bus.out_flags = head[19:16];
    end
  end

  assign bus.issue_ok     = credit_ok;
  assign bus.count        = count_q;
  assign bus.inflight     = inflight_q;
  assign bus.sticky_flags = sticky_q;
  assign bus.drop_err     = drop_err_q;
  assign bus.proto_err    = proto_err_q;
endmodule

// File: tb/tb_fpadd_result_collector.sv
// Directed bench for fpadd_result_collector (DEPTH=8, LATENCY=2).
module tb_fpadd_result_collector;
  localparam int DEPTH = 8;

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  fpadd_result_collector_if #(.DEPTH(DEPTH)) bus ();

  fpadd_result_collector #(.DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_fire        = 1'b0;
    bus.in_valid          = 1'b0;
    bus.in_result         = '0;
    bus.in_overflow       = 1'b0;
    bus.in_zero           = 1'b0;
    bus.in_nan            = 1'b0;
    bus.in_precision_lost = 1'b0;
    bus.out_ready         = 1'b0;
    bus.sticky_clr        = 1'b0;
  endtask

  logic [15:0] drain_exp [8];

  initial begin
    rstn = 1'b0;
    idle_inputs();
    tick();
    tick();

    // Reset state
    check("rst_count",     32'(bus.count), 0);
    check("rst_inflight",  32'(bus.inflight), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data), 0);
    check("rst_out_flags", 32'(bus.out_flags), 0);
    check("rst_issue_ok",  32'(bus.issue_ok), 1);
    check("rst_sticky",    32'(bus.sticky_flags), 0);
    check("rst_drop_err",  32'(bus.drop_err), 0);
    check("rst_proto_err", 32'(bus.proto_err), 0);
    rstn = 1'b1;
    tick();

    // Single operation: 1.0 + 1.0 = 2.0
    bus.issue_fire = 1'b1;
    tick();
    bus.issue_fire = 1'b0;
    check("single_inflight1", 32'(bus.inflight), 1);
    tick();
    bus.in_valid  = 1'b1;
    bus.in_result = 16'h4000;
    check("single_no_bypass", 32'(bus.out_valid), 0);
    tick();
    bus.in_valid = 1'b0;
    check("single_out_valid", 32'(bus.out_valid), 1);
    check("single_out_data",  32'(bus.out_data), 32'h4000);
    check("single_out_flags", 32'(bus.out_flags), 0);
    check("single_inflight0", 32'(bus.inflight), 0);
    check("single_count",     32'(bus.count), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("single_popped",    32'(bus.count), 0);
    check("single_proto",     32'(bus.proto_err), 0);

    // Credit exhaustion: fire 8 times, results return two cycles later
    for (int i = 0; i < 10; i++) begin
      check($sformatf("credit_ok_%0d", i), 32'(bus.issue_ok), (i < 8) ? 1 : 0);
      bus.issue_fire = (i < 8);
      bus.in_valid   = (i >= 2);
      bus.in_result  = 16'h3c00 + 16'(i - 2);
      tick();
    end
    idle_inputs();
    check("credit_count",    32'(bus.count), 8);
    check("credit_inflight", 32'(bus.inflight), 0);
    check("credit_issue_ok", 32'(bus.issue_ok), 0);
    check("credit_drop",     32'(bus.drop_err), 0);
    check("credit_proto",    32'(bus.proto_err), 0);
    check("credit_head",     32'(bus.out_data), 32'h3c00);

    // Full overrun without pop: dropped
    bus.in_valid  = 1'b1;
    bus.in_result = 16'hdead;
    tick();
    bus.in_valid = 1'b0;
    check("drop_err_set",    32'(bus.drop_err), 1);
    check("drop_count",      32'(bus.count), 8);
    check("drop_head",       32'(bus.out_data), 32'h3c00);
    check("drop_inflight",   32'(bus.inflight), 0);

    // Full with simultaneous pop: accepted
    bus.in_valid  = 1'b1;
    bus.in_result = 16'hbeef;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("fullpop_count",   32'(bus.count), 8);
    check("fullpop_head",    32'(bus.out_data), 32'h3c01);
    drain_exp = '{16'h3c01, 16'h3c02, 16'h3c03, 16'h3c04,
                  16'h3c05, 16'h3c06, 16'h3c07, 16'hbeef};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(bus.out_data), 32'(drain_exp[i]));
      tick();
    end
    bus.out_ready = 1'b0;
    check("drain_count",     32'(bus.count), 0);
    check("drain_out_valid", 32'(bus.out_valid), 0);
    bus.sticky_clr = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    check("clr_drop",        32'(bus.drop_err), 0);
    check("clr_proto",       32'(bus.proto_err), 0);

    // Exception flags and sticky behaviour
    bus.issue_fire = 1'b1;
    tick();
    tick();
    bus.issue_fire  = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_result   = 16'hffff;
    bus.in_overflow = 1'b1;
    tick();
    bus.in_overflow = 1'b0;
    bus.in_nan      = 1'b1;
    tick();
    idle_inputs();
    check("flags_ovf_head",  32'(bus.out_flags), 32'b0100);
    check("flags_ovf_data",  32'(bus.out_data), 32'hffff);
    check("flags_sticky",    32'(bus.sticky_flags), 32'b1100);
    check("flags_proto",     32'(bus.proto_err), 0);
    bus.out_ready = 1'b1;
    tick();
    check("flags_nan_head",  32'(bus.out_flags), 32'b1000);
    tick();
    bus.out_ready = 1'b0;
    check("flags_drained",   32'(bus.count), 0);
    bus.sticky_clr = 1'b1;
    tick();
    check("sticky_clr_only", 32'(bus.sticky_flags), 0);
    bus.in_valid = 1'b1;
    bus.in_zero  = 1'b1;
    tick();
    idle_inputs();
    check("sticky_set_wins", 32'(bus.sticky_flags), 32'b0010);
    check("proto_no_inflight", 32'(bus.proto_err), 1);
    check("proto_push_kept", 32'(bus.count), 1);
    check("proto_zero_head", 32'(bus.out_flags), 32'b0010);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready  = 1'b0;
    bus.sticky_clr = 1'b1;
    tick();
    bus.sticky_clr = 1'b0;
    check("proto_cleared",   32'(bus.proto_err), 0);

    // Issue while out of credit; inflight saturates at DEPTH
    bus.issue_fire = 1'b1;
    repeat (8) tick();
    bus.issue_fire = 1'b0;
    check("sat_inflight",    32'(bus.inflight), 8);
    check("sat_issue_ok",    32'(bus.issue_ok), 0);
    check("sat_proto",       32'(bus.proto_err), 0);
    bus.issue_fire = 1'b1;
    tick();
    bus.issue_fire = 1'b0;
    check("overissue_proto", 32'(bus.proto_err), 1);
    check("overissue_inflight", 32'(bus.inflight), 8);

    // Reset mid-stream with count=5, inflight=2
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.issue_fire = 1'b1;
      bus.in_valid   = (i >= 2);
      bus.in_result  = 16'h1000 + 16'(i);
      tick();
    end
    idle_inputs();
    check("mid_count",       32'(bus.count), 5);
    check("mid_inflight",    32'(bus.inflight), 2);
    check("mid_head",        32'(bus.out_data), 32'h1002);
    #2 rstn = 1'b0;
    #1;
    check("arst_count",      32'(bus.count), 0);
    check("arst_inflight",   32'(bus.inflight), 0);
    check("arst_out_valid",  32'(bus.out_valid), 0);
    check("arst_out_data",   32'(bus.out_data), 0);
    check("arst_issue_ok",   32'(bus.issue_ok), 1);
    check("arst_proto",      32'(bus.proto_err), 0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_empty",  32'(bus.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
